pll_reset_sequencer: RTL and testbench

//  Controller on the far side of the board PLL: drives the PLL reset, watches its lock indication, and releases the system reset.
//  - Runs on the free-running 50 MHz board clock.
//  - Holds the PLL in reset at power-up, then waits for lock and qualifies it as stable.
//  - Only then releases sys_rst_n to the 125/62.5 MHz logic (the Ethernet/bus core).
//  - Re-runs the sequence on lock timeout or lock loss, and counts retries and losses for status readout.

---
 rtl/pll_reset_sequencer.sv | 153 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies a synchronised lock,
// and releases the system reset only once lock has been stable long enough.
module pll_reset_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 8
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             pll_locked,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic             pll_ok,
   output logic [CNT_W-1:0] retry_cnt,
   output logic [CNT_W-1:0] loss_cnt,
   output logic [2:0]       seq_state
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_LOST      = 3'd4
   } seq_state_t;

   // The shared timer only ever holds (duration - 1), so clog2 of the longest duration suffices.
   localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TW-1:0]    RST_LOAD    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0]    LOCK_LOAD   = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0]    STABLE_LOAD = TW'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   seq_state_t    state_q;
   seq_state_t    state_d;
   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;
   logic          lk_meta;
   logic          lk;
   logic          retry_inc;
   logic          loss_inc;
   logic          in_run;
   logic          rel_q;
   logic          ok_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         lk_meta <= 1'b0;
         lk      <= 1'b0;
      end else begin
         lk_meta <= pll_locked;
         lk      <= lk_meta;
      end
   end

   // State register together with the shared down-counter.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q <= S_PLL_RST;
         cnt_q   <= RST_LOAD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
      case (state_q)
         S_PLL_RST: begin
            if (cnt_q == '0) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lk) begin
               state_d = S_STABLE;
            end else if (cnt_q == '0) begin
               state_d   = S_PLL_RST;
               retry_inc = 1'b1;
            end
         end
         S_STABLE: begin
            if (!lk)                 state_d = S_WAIT_LOCK;
            else if (cnt_q == '0)    state_d = S_RUN;
         end
         S_RUN: begin
            if (!lk) begin
               state_d  = S_LOST;
               loss_inc = 1'b1;
            end
         end
         S_LOST:  state_d = S_PLL_RST;
         default: state_d = S_PLL_RST;
      endcase

      // Reload on any state change so each timed state starts with a full window.
      if (state_d != state_q) begin
         case (state_d)
            S_PLL_RST:   cnt_d = RST_LOAD;
            S_WAIT_LOCK: cnt_d = LOCK_LOAD;
            S_STABLE:    cnt_d = STABLE_LOAD;
            default:     cnt_d = '0;
         endcase
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_comb begin
      pll_rst = 1'b0;
      in_run  = 1'b0;
      case (state_q)
         S_PLL_RST: pll_rst = 1'b1;
         S_RUN:     in_run  = 1'b1;
         default:   ;
      endcase
   end

   // Release is registered (one cycle after RUN entry); gating with in_run drops it the moment RUN is left.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         rel_q <= 1'b0;
         ok_q  <= 1'b0;
      end else begin
         rel_q <= in_run;
         ok_q  <= in_run;
      end
   end

   assign sys_rst_n = rel_q & in_run;
   assign pll_ok    = ok_q & in_run;
   assign seq_state = state_q;

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         retry_cnt <= '0;
         loss_cnt  <= '0;
      end else begin
         if (retry_inc && (retry_cnt != CNT_MAX)) retry_cnt <= retry_cnt + CNT_W'(1);
         if (loss_inc && (loss_cnt != CNT_MAX))   loss_cnt  <= loss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed table, corner sequences,
// and randomized lock behaviour against a cycle-level reference model.
module tb_pll_reset_sequencer;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int CNT_W         = 2;
   localparam int CNT_SAT       = (1 << CNT_W) - 1;

   logic             refclk = 1'b0;
   logic             rst_n;
   logic             pll_locked;
   logic             pll_rst;
   logic             sys_rst_n;
   logic             pll_ok;
   logic [CNT_W-1:0] retry_cnt;
   logic [CNT_W-1:0] loss_cnt;
   logic [2:0]       seq_state;

   int n_checks = 0;
   int n_errors = 0;

   pll_reset_sequencer #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked),
      .pll_rst   (pll_rst),
      .sys_rst_n (sys_rst_n),
      .pll_ok    (pll_ok),
      .retry_cnt (retry_cnt),
      .loss_cnt  (loss_cnt),
      .seq_state (seq_state)
   );

   always #10 refclk = ~refclk;

   // Reference model: phase number, cycles spent in the phase, and the last two lock samples.
   int   m_phase, m_age, m_retry, m_loss;
   logic m_h0, m_h1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 30) $display("FAIL %s @%0t actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [9:0] dut_vec();
      return {pll_rst, sys_rst_n, pll_ok, retry_cnt, loss_cnt, seq_state};
   endfunction

   function automatic logic [9:0] model_vec();
      logic run_out;
      run_out = (m_phase == 3) && (m_age >= 1);
      return {m_phase == 0, run_out, run_out, CNT_W'(m_retry), CNT_W'(m_loss), 3'(m_phase)};
   endfunction

   task automatic model_step(input logic rn, input logic lock);
      logic lk;
      if (!rn) begin
         m_phase = 0; m_age = 0; m_retry = 0; m_loss = 0; m_h0 = 1'b0; m_h1 = 1'b0;
         return;
      end
      lk = m_h1;
      case (m_phase)
         0: if (m_age == RST_CYCLES - 1) begin m_phase = 1; m_age = 0; end else m_age++;
         1: if (lk) begin
               m_phase = 2; m_age = 0;
            end else if (m_age == LOCK_TIMEOUT - 1) begin
               m_phase = 0; m_age = 0;
               m_retry = (m_retry < CNT_SAT) ? m_retry + 1 : CNT_SAT;
            end else m_age++;
         2: if (!lk) begin
               m_phase = 1; m_age = 0;
            end else if (m_age == STABLE_CYCLES - 1) begin
               m_phase = 3; m_age = 0;
            end else m_age++;
         3: if (!lk) begin
               m_phase = 4; m_age = 0;
               m_loss = (m_loss < CNT_SAT) ? m_loss + 1 : CNT_SAT;
            end else if (m_age < 1000) m_age++;
         default: begin m_phase = 0; m_age = 0; end
      endcase
      m_h1 = m_h0;
      m_h0 = lock;
   endtask

   task automatic tick(input logic rn, input logic lock);
      rst_n      = rn;
      pll_locked = lock;
      @(posedge refclk);
      #1;
      model_step(rn, lock);
      check("cycle", 32'(dut_vec()), 32'(model_vec()));
   endtask

   task automatic wait_state(input logic [2:0] target, input logic lock, input int budget);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         tick(1'b1, lock);
         if (seq_state == target) hit = 1'b1;
      end
      check($sformatf("wait_state_%0d", target), 32'(hit), 32'd1);
   endtask

   typedef struct {
      logic       rn;
      logic       lock;
      int         n;
      logic [2:0] st;
      logic       prst;
      logic       sys;
      logic       ok;
      logic [1:0] retry;
      logic [1:0] loss;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [2:0] r_before;
      rst_n      = 1'b0;
      pll_locked = 1'b1;

      // Power-up with lock high, then loss in RUN, then a first lock timeout.
      tbl.push_back('{1'b0, 1'b1,  3, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back('{1'b1, 1'b1,  3, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back('{1'b1, 1'b1,  1, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back('{1'b1, 1'b1,  1, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back('{1'b1, 1'b1,  7, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back('{1'b1, 1'b1,  1, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back('{1'b1, 1'b1,  1, 3'd3, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0});
      tbl.push_back('{1'b1, 1'b0,  2, 3'd3, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0});
      tbl.push_back('{1'b1, 1'b0,  1, 3'd4, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1});
      tbl.push_back('{1'b1, 1'b0,  1, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1});
      tbl.push_back('{1'b1, 1'b0,  3, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1});
      tbl.push_back('{1'b1, 1'b0,  1, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1});
      tbl.push_back('{1'b1, 1'b0, 19, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1});
      tbl.push_back('{1'b1, 1'b0,  1, 3'd0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1});

      foreach (tbl[i]) begin
         repeat (tbl[i].n) tick(tbl[i].rn, tbl[i].lock);
         check($sformatf("table_%0d", i), 32'(dut_vec()),
               32'({tbl[i].prst, tbl[i].sys, tbl[i].ok, tbl[i].retry, tbl[i].loss, tbl[i].st}));
      end

      // Lock held low: one retry per 24-cycle round, saturating at 3.
      repeat (24) tick(1'b1, 1'b0);
      check("retry_2", 32'(retry_cnt), 32'd2);
      repeat (24) tick(1'b1, 1'b0);
      check("retry_3", 32'(retry_cnt), 32'd3);
      repeat (24) tick(1'b1, 1'b0);
      check("retry_sat", 32'(retry_cnt), 32'd3);
      check("retry_sat_state", 32'(seq_state), 32'd0);

      // One-cycle glitch in STABLE restarts the full window without touching counters.
      wait_state(3'd2, 1'b1, 40);
      repeat (4) tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      wait_state(3'd1, 1'b1, 10);
      check("glitch_counters", 32'({retry_cnt, loss_cnt}), 32'({2'd3, 2'd1}));
      wait_state(3'd2, 1'b1, 10);
      repeat (STABLE_CYCLES - 1) tick(1'b1, 1'b1);
      check("glitch_window_state", 32'(seq_state), 32'd2);
      check("glitch_window_sys", 32'(sys_rst_n), 32'd0);
      tick(1'b1, 1'b1);
      check("relock_run", 32'(seq_state), 32'd3);
      tick(1'b1, 1'b1);
      check("relock_sys", 32'({sys_rst_n, pll_ok}), 32'b11);

      // Reset while in RUN.
      tick(1'b0, 1'b1);
      check("reset_in_run", 32'(dut_vec()), 32'({1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0}));

      // Lock arrives exactly on the final timeout cycle: lock wins.
      wait_state(3'd1, 1'b0, 10);
      repeat (LOCK_TIMEOUT - 3) tick(1'b1, 1'b0);
      repeat (3) tick(1'b1, 1'b1);
      check("late_lock_state", 32'(seq_state), 32'd2);
      check("late_lock_retry", 32'(retry_cnt), 32'd0);

      // Reset mid-STABLE.
      repeat (3) tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      check("reset_in_stable", 32'(dut_vec()), 32'({1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0}));

      // Lock one cycle too late: timeout wins.
      wait_state(3'd1, 1'b0, 10);
      r_before = 3'(retry_cnt);
      repeat (LOCK_TIMEOUT - 2) tick(1'b1, 1'b0);
      repeat (2) tick(1'b1, 1'b1);
      check("too_late_state", 32'(seq_state), 32'd0);
      check("too_late_retry", 32'(retry_cnt), 32'(r_before) + 32'd1);

      // Randomized lock bursts with occasional resets.
      for (int b = 0; b < 150; b++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(0, 1));
         len = lvl ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
         if ($urandom_range(0, 49) == 0) tick(1'b0, lvl);
         else repeat (len) tick(1'b1, lvl);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
